clock_period_meter: RTL and testbench
=====================================

# clock_period_meter

Measures the half-period of a slow, asynchronous square wave, such as a divided clock or an external tick, in `clock_in` cycles. Reports each measurement with a one-cycle valid strobe and asserts a lock flag when consecutive measurements agree within a tolerance. It is the receiving end of the clock-divider path: a signal that toggles every N `clock_in` cycles reads back `half_period` = N. It is used for self-check of divider outputs and for frequency monitoring of external inputs.

## Interface
- `CNT_WIDTH`, default 24: width of the interval counter and of `half_period`.
- `TIMEOUT_CYCLES`, default 8000000: cycles without a detected edge before `timeout` is declared. Must be at most 2^CNT_WIDTH-1.
- `TOLERANCE`, default 2: maximum absolute difference between consecutive measurements that still counts as agreement.
- `clock_in` input 1: system clock. All logic is on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `slow_in` input 1: measured signal, asynchronous to `clock_in`.
- `enable` input 1: measurement enable; synchronous, level-sensitive.
- `half_period` output CNT_WIDTH: last measured interval between consecutive `slow_in` transitions.
- `meas_valid` output 1: one-cycle pulse when `half_period` is updated.
- `locked` output 1: consecutive measurements agree within `TOLERANCE`.
- `timeout` output 1: no transition seen for `TIMEOUT_CYCLES`.

## Operation
- Input path:
  - `slow_in` passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
  - `edge_det` = s2 XOR s3. Both rising and falling transitions are detected.
  - Latency from `slow_in` change to `edge_det` is fixed at 3 cycles, so it cancels out of intervals.
- States:
  - IDLE: entered when `enable`=0. `count`, `timeout`, `locked` and `prev_ok` are held at 0.
  - ARM: wait for the first edge. The next edge goes to MEASURE and sets `count`=0. No measurement is made in ARM.
  - MEASURE: each cycle without an edge, `count` increments.
- Measurement, on an edge in MEASURE:
  - `half_period` <= `count`+1, `meas_valid` <= 1, `count` <= 0.
  - Consequence: edges detected at cycles t0 and t1 give t1-t0.
- Lock, evaluated on each measurement M with previous value P:
  - Compute |M-P| in CNT_WIDTH bits, unsigned; subtract the smaller from the larger, with no wrap.
  - If `prev_ok`=1 and |M-P| <= `TOLERANCE`: `locked` <= 1.
  - Otherwise: `locked` <= 0.
  - Then `prev_ok` <= 1 and P <= M.
  - `prev_ok` clears whenever ARM is entered.
- Timeout, when in MEASURE with `count` = `TIMEOUT_CYCLES`-1 and no edge:
  - Next state is ARM; `timeout` <= 1, `locked` <= 0, `count` <= 0.
  - `half_period` holds its value.
  - `timeout` stays high until the next `meas_valid` or until `enable` goes low.
- Transitions:
  - IDLE -> ARM when `enable`=1.
  - Any state -> IDLE on the first clock with `enable`=0. `meas_valid` is not generated on that clock, and `half_period` holds.
- Simultaneous events:
  - Edge and timeout condition in the same cycle: the edge wins. The measurement is `TIMEOUT_CYCLES` and `timeout` is not set.
  - `enable` falling in the same cycle as an edge: disable wins and no measurement is made.
- Reset (asynchronous, any time):
  - `half_period`=0, `meas_valid`=0, `locked`=0, `timeout`=0.
  - State IDLE; `count`, P, `prev_ok` and synchronizer flops all 0.

## Timing
- All outputs are registered.
- `meas_valid` and the new `half_period` appear together and are valid for exactly 1 cycle / until the next update.
- `locked` updates on the same clock as `meas_valid`.
- Edge-to-report latency: `slow_in` change -> `meas_valid` high is 3 cycles, plus 1 register stage = 4 cycles.
- Minimum measurable interval is 1, for `slow_in` toggling every `clock_in` cycle.
- `timeout` asserts exactly `TIMEOUT_CYCLES` cycles after the last detected edge.
- Inputs must be stable for 1 cycle to be seen.

## Test plan
- Toggle `slow_in` every 10 cycles, `enable`=1:
  - 1st detected edge: no pulse.
  - 2nd: `meas_valid`, `half_period`=10, `locked`=0.
  - 3rd: `half_period`=10, `locked`=1, held thereafter.
- Jitter, `TOLERANCE`=2, intervals 10, 11, 13, 16:
  - `locked` reads 0, 1, 1, then 0 at the 16 measurement (|16-13|=3).
- Timeout, `TIMEOUT_CYCLES`=20, locked at 10, then stop toggling:
  - `timeout`=1 and `locked`=0 exactly 20 cycles after the last edge.
  - Resume toggling every 10: the first edge gives no pulse; the second gives `half_period`=10 and `timeout`=0.
- `enable` dropped for 1 cycle mid-interval while locked:
  - Next clock: `locked`=0, `timeout`=0, no `meas_valid`, `half_period` unchanged.
  - Re-arm requires two further edges before the next `meas_valid`.
- `reset_n` pulsed low between clock edges mid-measurement:
  - All outputs 0 immediately, without waiting for a clock.
  - After release, behaviour is identical to the first scenario.
- `slow_in` toggling every cycle:
  - `half_period`=1 and `locked`=1 from the 2nd measurement.
- Edge coinciding with the timeout boundary (interval = 20, `TIMEOUT_CYCLES`=20):
  - `half_period`=20 and `timeout`=0.

Source files
------------

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - half-period meter for a slow asynchronous square wave with lock and timeout
module clock_period_meter #(
    parameter int CNT_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 8000000,
    parameter int TOLERANCE      = 2
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 slow_in,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 meas_valid,
    output logic                 locked,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TOL          = CNT_WIDTH'(TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] ONE          = CNT_WIDTH'(1);

    state_t               state;
    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic                 edge_q;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] prev;
    logic                 prev_ok;

    logic [CNT_WIDTH-1:0] meas;
    logic [CNT_WIDTH-1:0] diff;
    logic                 within_tol;
    logic                 timeout_hit;

    // Fixed-latency input pipeline; the delay is identical for every edge so it cancels out of intervals.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1     <= slow_in;
            s2     <= s1;
            s3     <= s2;
            edge_q <= s2 ^ s3;
        end
    end

    // Interval counts from 0 on the edge clock, so the measurement is count+1.
    assign meas        = count + ONE;
    assign diff        = (meas >= prev) ? (meas - prev) : (prev - meas);
    assign within_tol  = (diff <= TOL);
    assign timeout_hit = (count == TIMEOUT_LAST);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            prev        <= '0;
            prev_ok     <= 1'b0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                count   <= '0;
                prev_ok <= 1'b0;
                locked  <= 1'b0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= ARM;
                        count   <= '0;
                        prev_ok <= 1'b0;
                    end
                    ARM: begin
                        if (edge_q) begin
                            state <= MEASURE;
                            count <= '0;
                        end
                    end
                    MEASURE: begin
                        // An edge on the timeout boundary is a valid measurement, so it is checked first.
                        if (edge_q) begin
                            half_period <= meas;
                            meas_valid  <= 1'b1;
                            count       <= '0;
                            timeout     <= 1'b0;
                            locked      <= prev_ok && within_tol;
                            prev_ok     <= 1'b1;
                            prev        <= meas;
                        end else if (timeout_hit) begin
                            state   <= ARM;
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            count   <= '0;
                            prev_ok <= 1'b0;
                        end else begin
                            count <= count + ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - table-driven and randomized bench for clock_period_meter
module tb_clock_period_meter;

    localparam int W    = 16;
    localparam int TMO  = 20;
    localparam int TOL  = 2;
    localparam int LAT  = 4;

    logic          clock_in;
    logic          reset_n;
    logic          slow_in;
    logic          enable;
    logic [W-1:0]  half_period;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    clock_period_meter #(
        .CNT_WIDTH      (W),
        .TIMEOUT_CYCLES (TMO),
        .TOLERANCE      (TOL)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .slow_in     (slow_in),
        .enable      (enable),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks cycle numbers of detected transitions and applies the rules arithmetically.
    int cyc;
    int m_phase;   // 0 disabled, 1 waiting for first edge, 2 measuring
    int m_last;
    int m_prev;
    int m_hp;
    bit m_valid;
    bit m_locked;
    bit m_timeout;
    bit m_prevok;
    bit smp[LAT+1];

    task automatic model_reset();
        m_phase = 0; m_last = 0; m_prev = 0; m_hp = 0;
        m_valid = 0; m_locked = 0; m_timeout = 0; m_prevok = 0;
        for (int i = 0; i <= LAT; i++) smp[i] = 1'b0;
    endtask

    task automatic model_clock();
        bit det;
        int m;
        int d;
        cyc++;
        for (int i = LAT; i > 0; i--) smp[i] = smp[i-1];
        smp[0] = slow_in;
        // A transition sampled LAT-1 clocks ago is acted on now.
        det = (smp[LAT-1] != smp[LAT]);
        m_valid = 1'b0;
        if (!enable) begin
            m_phase = 0; m_locked = 0; m_timeout = 0; m_prevok = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_prevok = 0;
        end else if (m_phase == 1) begin
            if (det) begin
                m_phase = 2; m_last = cyc;
            end
        end else begin
            if (det) begin
                m = cyc - m_last;
                d = (m > m_prev) ? m - m_prev : m_prev - m;
                m_locked  = m_prevok && (d <= TOL);
                m_prevok  = 1;
                m_prev    = m;
                m_hp      = m;
                m_valid   = 1;
                m_timeout = 0;
                m_last    = cyc;
            end else if (cyc - m_last == TMO) begin
                m_phase = 1; m_timeout = 1; m_locked = 0; m_prevok = 0;
            end
        end
    endtask

    task automatic step(input bit en, input bit tog);
        @(negedge clock_in);
        enable = en;
        if (tog) slow_in = ~slow_in;
        @(posedge clock_in);
        model_clock();
        #1;
        check("model half_period", int'(half_period), m_hp);
        check("model meas_valid", int'(meas_valid), int'(m_valid));
        check("model locked", int'(locked), int'(m_locked));
        check("model timeout", int'(timeout), int'(m_timeout));
    endtask

    typedef struct {
        int interval;
        bit valid;
        int hp;
        bit lck;
        bit tmo;
    } vec_t;

    vec_t vecs[13];

    // Each vector: toggle slow_in `interval` cycles after the previous toggle, check when the report is due.
    task automatic run_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            repeat (vecs[i].interval - LAT) step(1, 0);
            step(1, 1);
            repeat (LAT - 1) step(1, 0);
            check($sformatf("vec%0d meas_valid", i), int'(meas_valid), int'(vecs[i].valid));
            check($sformatf("vec%0d half_period", i), int'(half_period), vecs[i].hp);
            check($sformatf("vec%0d locked", i), int'(locked), int'(vecs[i].lck));
            check($sformatf("vec%0d timeout", i), int'(timeout), int'(vecs[i].tmo));
        end
    endtask

    initial begin
        vecs[0]  = '{10, 0, 0,  0, 0};
        vecs[1]  = '{10, 1, 10, 0, 0};
        vecs[2]  = '{10, 1, 10, 1, 0};
        vecs[3]  = '{10, 1, 10, 1, 0};
        vecs[4]  = '{10, 0, 10, 0, 1};
        vecs[5]  = '{10, 1, 10, 0, 0};
        vecs[6]  = '{11, 1, 11, 1, 0};
        vecs[7]  = '{13, 1, 13, 1, 0};
        vecs[8]  = '{16, 1, 16, 0, 0};
        vecs[9]  = '{20, 1, 20, 0, 0};
        vecs[10] = '{20, 1, 20, 1, 0};
        vecs[11] = '{10, 0, 20, 0, 0};
        vecs[12] = '{10, 1, 10, 0, 0};

        cyc = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        slow_in = 1'b0;
        model_reset();
        #1;
        check("reset half_period", int'(half_period), 0);
        check("reset meas_valid", int'(meas_valid), 0);
        check("reset locked", int'(locked), 0);
        check("reset timeout", int'(timeout), 0);
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        reset_n = 1'b1;

        // Steady toggling every 10 cycles: arm, first report unlocked, then locked.
        run_vectors(0, 3);

        // Stop toggling: timeout exactly TMO cycles after the last detected edge.
        repeat (TMO - 1) step(1, 0);
        check("pre-timeout timeout", int'(timeout), 0);
        check("pre-timeout locked", int'(locked), 1);
        step(1, 0);
        check("timeout timeout", int'(timeout), 1);
        check("timeout locked", int'(locked), 0);
        check("timeout half_period", int'(half_period), 10);

        // Resume, jitter 10/11/13/16, then intervals on the timeout boundary.
        run_vectors(4, 10);

        // Enable dropped for one clock while locked.
        repeat (2) step(1, 0);
        step(0, 0);
        check("disable locked", int'(locked), 0);
        check("disable timeout", int'(timeout), 0);
        check("disable meas_valid", int'(meas_valid), 0);
        check("disable half_period", int'(half_period), 20);
        run_vectors(11, 12);

        // Asynchronous reset pulse between clock edges, mid-measurement.
        repeat (3) step(1, 0);
        #1;
        reset_n = 1'b0;
        slow_in = 1'b0;
        model_reset();
        #1;
        check("async reset half_period", int'(half_period), 0);
        check("async reset meas_valid", int'(meas_valid), 0);
        check("async reset locked", int'(locked), 0);
        check("async reset timeout", int'(timeout), 0);
        reset_n = 1'b1;
        run_vectors(0, 3);

        // Fastest input: toggling every clock reads back 1 and locks.
        repeat (12) step(1, 1);
        check("fast half_period", int'(half_period), 1);
        check("fast locked", int'(locked), 1);
        check("fast meas_valid", int'(meas_valid), 1);

        // Random gaps (including past the timeout) and random enable drops against the model.
        for (int s = 0; s < 150; s++) begin
            int k;
            int g;
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, 3);
                repeat (k) step(0, 0);
            end else begin
                g = $urandom_range(1, 28);
                repeat (g - 1) step(1, 0);
                step(1, 1);
            end
        end
        repeat (30) step(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
